// File: rtl/vchip8_byte_mem_master.sv
// vchip8_byte_mem_master: turns byte-addressed vChip8 core requests into 32-bit Avalon-MM
// word accesses. Sequential byte reads are streamed out over valid/ready; single-byte
// writes use byte lanes.
// Optional feature macro: VCHIP8_MEM_MASTER_PREFETCH_EN adds a second word buffer so the
// next word read overlaps draining of the current word (no idle gap at word boundaries).
module vchip8_byte_mem_master #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W+1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        cmd_wdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [7:0]        rd_data,
    output logic              rd_last,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              avm_clken
);

    localparam int unsigned BA_W = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT,
        S_WR,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [BA_W-1:0]    addr_q;      // byte address of the byte currently presented
    logic [LEN_W-1:0]   remain_q;    // bytes still to hand over, including the current one
    logic [31:0]        word_q;      // word holding the current byte
    logic               rd_valid_q;
    logic [7:0]         rd_data_q;
    logic               rd_last_q;
    logic               done_q;
    logic [ADDR_W-1:0]  avm_address_q;
    logic [3:0]         avm_be_q;
    logic               avm_cs_q;
    logic               avm_we_q;
    logic [31:0]        avm_wdata_q;

    logic               hs_c;
    logic [BA_W-1:0]    addr_inc_c;

    assign hs_c       = (state_q == S_RD_OUT) && rd_ready;
    assign addr_inc_c = addr_q + BA_W'(1);

`ifdef VCHIP8_MEM_MASTER_PREFETCH_EN
    localparam int unsigned CNT_W = LEN_W + 2;

    logic [ADDR_W-1:0]  fetch_addr_q;   // next word address to prefetch
    logic [CNT_W-1:0]   words_left_q;   // words of this command not yet requested
    logic [31:0]        buf1_q;         // second word buffer
    logic               buf1_vld_q;
    logic               pf_iss_q;       // prefetch strobe on the bus this cycle
    logic               pf_pend_q;      // prefetch data on avm_readdata this cycle
    logic [CNT_W-1:0]   words_total_c;
    logic [31:0]        next_word_c;
    logic               cross_c;
    logic               pf_issue_c;

    assign words_total_c = CNT_W'((CNT_W'(cmd_addr[1:0]) + CNT_W'(cmd_len) + CNT_W'(3)) >> 2);
    // Next word comes from the second buffer, or straight off the bus if it lands this cycle.
    assign next_word_c   = buf1_vld_q ? buf1_q : avm_readdata;
    assign cross_c       = hs_c && (addr_q[1:0] == 2'd3) && (remain_q != LEN_W'(1));
    // One word may be outstanding beyond the current one; its slot frees on a word crossing.
    assign pf_issue_c    = (words_left_q != '0)
                         && ((state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT) || (state_q == S_RD_OUT))
                         && (!(buf1_vld_q || pf_iss_q || pf_pend_q) || cross_c);
`endif

    // Command sequencing, byte streaming and bus strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remain_q      <= '0;
            word_q        <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_last_q     <= 1'b0;
            done_q        <= 1'b0;
            avm_address_q <= '0;
            avm_be_q      <= '0;
            avm_cs_q      <= 1'b0;
            avm_we_q      <= 1'b0;
            avm_wdata_q   <= '0;
`ifdef VCHIP8_MEM_MASTER_PREFETCH_EN
            fetch_addr_q  <= '0;
            words_left_q  <= '0;
            buf1_q        <= '0;
            buf1_vld_q    <= 1'b0;
            pf_iss_q      <= 1'b0;
            pf_pend_q     <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            avm_cs_q <= 1'b0;
            avm_we_q <= 1'b0;
`ifdef VCHIP8_MEM_MASTER_PREFETCH_EN
            pf_iss_q  <= 1'b0;
            pf_pend_q <= pf_iss_q;
`endif
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q        <= cmd_addr;
                        remain_q      <= cmd_len;
                        avm_address_q <= cmd_addr[BA_W-1:2];
                        if (cmd_write) begin
                            avm_cs_q    <= 1'b1;
                            avm_we_q    <= 1'b1;
                            avm_be_q    <= 4'b0001 << cmd_addr[1:0];
                            avm_wdata_q <= {4{cmd_wdata}};
                            state_q     <= S_WR;
                        end else if (cmd_len == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            avm_cs_q <= 1'b1;
                            avm_be_q <= 4'hF;
                            state_q  <= S_RD_ISSUE;
`ifdef VCHIP8_MEM_MASTER_PREFETCH_EN
                            fetch_addr_q <= cmd_addr[BA_W-1:2] + ADDR_W'(1);
                            words_left_q <= words_total_c - CNT_W'(1);
`endif
                        end
                    end
                end
                S_RD_ISSUE: begin
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    word_q     <= avm_readdata;
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= avm_readdata[{addr_q[1:0], 3'b000} +: 8];
                    rd_last_q  <= (remain_q == LEN_W'(1));
                    state_q    <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (rd_ready) begin
                        addr_q   <= addr_inc_c;
                        remain_q <= remain_q - LEN_W'(1);
                        if (remain_q == LEN_W'(1)) begin
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else if (addr_q[1:0] == 2'd3) begin
`ifdef VCHIP8_MEM_MASTER_PREFETCH_EN
                            word_q    <= next_word_c;
                            rd_data_q <= next_word_c[7:0];
                            rd_last_q <= (remain_q == LEN_W'(2));
`else
                            rd_valid_q    <= 1'b0;
                            avm_cs_q      <= 1'b1;
                            avm_be_q      <= 4'hF;
                            avm_address_q <= addr_inc_c[BA_W-1:2];
                            state_q       <= S_RD_ISSUE;
`endif
                        end else begin
                            rd_data_q <= word_q[{addr_inc_c[1:0], 3'b000} +: 8];
                            rd_last_q <= (remain_q == LEN_W'(2));
                        end
                    end
                end
                S_WR: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef VCHIP8_MEM_MASTER_PREFETCH_EN
            if (pf_issue_c) begin
                avm_cs_q      <= 1'b1;
                avm_be_q      <= 4'hF;
                avm_address_q <= fetch_addr_q;
                fetch_addr_q  <= fetch_addr_q + ADDR_W'(1);
                words_left_q  <= words_left_q - CNT_W'(1);
                pf_iss_q      <= 1'b1;
            end
            if (cross_c) begin
                buf1_vld_q <= 1'b0;
            end else if (pf_pend_q) begin
                buf1_q     <= avm_readdata;
                buf1_vld_q <= 1'b1;
            end
`endif
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_last        = rd_last_q;
    assign done           = done_q;
    assign avm_address    = avm_address_q;
    assign avm_byteenable = avm_be_q;
    assign avm_chipselect = avm_cs_q;
    assign avm_write      = avm_we_q;
    assign avm_writedata  = avm_wdata_q;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_vchip8_byte_mem_master.sv
// Bench for vchip8_byte_mem_master: RAM slave model, byte-level reference memory,
// directed vectors plus randomized reads/writes with random downstream stalls.
`timescale 1ns/1ps
module tb_vchip8_byte_mem_master;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned LEN_W  = 8;
    localparam int          NWORDS = 1 << ADDR_W;
    localparam int          NBYTES = 1 << (ADDR_W + 2);
`ifdef VCHIP8_MEM_MASTER_PREFETCH_EN
    localparam int          WORD_GAP = 0;
`else
    localparam int          WORD_GAP = 2;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [15:0]       cmd_addr;
    logic [7:0]        cmd_len;
    logic [7:0]        cmd_wdata;
    logic              rd_valid;
    logic              rd_ready;
    logic [7:0]        rd_data;
    logic              rd_last;
    logic              done;
    logic [13:0]       avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_clken;

    logic [31:0]       ram [NWORDS];
    logic [7:0]        ref_mem [NBYTES];
    logic              ram_load;
    logic [7:0]        got_bytes [$];
    int                n_vec = 0;
    int                n_bad = 0;

    initial forever #5 clk = ~clk;

    vchip8_byte_mem_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_wdata      (cmd_wdata),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .done           (done),
        .avm_address    (avm_address),
        .avm_byteenable (avm_byteenable),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_clken      (avm_clken)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 32'd16) return 32'h44332211;
        if (i == 32'd17) return 32'h88776655;
        return (i * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    // On-chip RAM slave: read data valid the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < NWORDS; i++) ram[i] <= init_word(32'(i));
        end else if (avm_chipselect && avm_write) begin
            for (int b = 0; b < 4; b++)
                if (avm_byteenable[b]) ram[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
        end
        if (avm_chipselect && !avm_write) avm_readdata <= ram[avm_address];
        else avm_readdata <= $urandom();
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sequential read of len bytes from byte address addr; rnd selects random rd_ready stalls.
    task automatic do_read(input logic [15:0] addr, input int len, input bit rnd);
        logic [13:0] exp_words [$];
        logic [15:0] ba;
        logic [13:0] w;
        logic [13:0] lw;
        logic [7:0]  pd;
        logic        pl;
        bit          stall;
        bit          got_done;
        bit          seen_valid;
        int          k;
        int          nb;
        int          n_rd;
        int          hs_k;
        int          lane0;
        lw = '0;
        for (int i = 0; i < len; i++) begin
            ba = addr + 16'(i);
            w  = ba[15:2];
            if (i == 0 || w != lw) exp_words.push_back(w);
            lw = w;
        end
        got_bytes.delete();
        lane0 = int'(addr[1:0]);
        @(negedge clk);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        rd_ready  = 1'b0;
        k = 0; nb = 0; n_rd = 0; hs_k = 0;
        stall = 1'b0; got_done = 1'b0; seen_valid = 1'b0;
        pd = '0; pl = 1'b0;
        while (!got_done && k < 2000) begin
            @(negedge clk);
            k++;
            cmd_valid = 1'b0;
            if (k == 1) check_eq("cmd_ready_busy", 32'(cmd_ready), 32'h0);
            if (avm_chipselect) begin
                check_eq("rd_no_write", 32'(avm_write), 32'h0);
                check_eq("rd_be", 32'(avm_byteenable), 32'hF);
                if (n_rd >= exp_words.size()) check_eq("rd_extra_access", 32'(n_rd + 1), 32'(exp_words.size()));
                else check_eq("rd_word_addr", 32'(avm_address), 32'(exp_words[n_rd]));
                n_rd++;
            end
            if (stall) begin
                check_eq("stall_valid", 32'(rd_valid), 32'h1);
                check_eq("stall_data", 32'(rd_data), 32'(pd));
                check_eq("stall_last", 32'(rd_last), 32'(pl));
            end
            rd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rd_valid) begin
                if (!seen_valid) check_eq("first_latency", 32'(k), 32'd3);
                seen_valid = 1'b1;
                if (nb >= len) check_eq("rd_valid_extra", 32'(nb + 1), 32'(len));
                else begin
                    if (!rnd) check_eq("byte_cycle", 32'(k), 32'(3 + nb + WORD_GAP * ((lane0 + nb) >> 2)));
                    if (rd_ready) begin
                        ba = addr + 16'(nb);
                        check_eq("rd_data", 32'(rd_data), 32'(ref_mem[ba]));
                        check_eq("rd_last", 32'(rd_last), 32'(nb == len - 1));
                        got_bytes.push_back(rd_data);
                        nb++;
                        hs_k = k;
                    end
                end
            end
            stall = rd_valid && !rd_ready;
            pd = rd_data;
            pl = rd_last;
            if (done) begin
                got_done = 1'b1;
                check_eq("done_bytes", 32'(nb), 32'(len));
                check_eq("done_cycle", 32'(k), (len == 0) ? 32'd1 : 32'(hs_k + 1));
            end
        end
        if (!got_done) check_eq("read_timeout", 32'(k), 32'h0);
        check_eq("rd_access_total", 32'(n_rd), 32'(exp_words.size()));
        rd_ready = 1'b0;
    endtask

    // Single-byte write; checks the one-cycle strobe and the done pulse.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        logic [3:0] be_exp;
        be_exp = 4'b0001 << addr[1:0];
        @(negedge clk);
        check_eq("cmd_ready_idle_w", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_len   = 8'($urandom_range(0, 255));
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("wr_cs", 32'(avm_chipselect), 32'h1);
        check_eq("wr_we", 32'(avm_write), 32'h1);
        check_eq("wr_addr", 32'(avm_address), 32'(addr[15:2]));
        check_eq("wr_be", 32'(avm_byteenable), 32'(be_exp));
        check_eq("wr_data", avm_writedata, {4{data}});
        check_eq("wr_no_early_done", 32'(done), 32'h0);
        @(negedge clk);
        check_eq("wr_done", 32'(done), 32'h1);
        check_eq("wr_cs_off", 32'(avm_chipselect), 32'h0);
        ref_mem[addr] = data;
    endtask

    initial begin
        logic [31:0] v;
        logic [15:0] a;
        int          t;
        reset_n   = 1'b0;
        ram_load  = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_wdata = '0;
        rd_ready  = 1'b0;
        for (int wi = 0; wi < NWORDS; wi++) begin
            v = init_word(32'(wi));
            for (int b = 0; b < 4; b++) ref_mem[4*wi + b] = v[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        ram_load = 1'b0;
        check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_cs", 32'(avm_chipselect), 32'h0);
        check_eq("rst_we", 32'(avm_write), 32'h0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check_eq("clken", 32'(avm_clken), 32'h1);
        reset_n = 1'b1;

        // Directed vectors
        do_read(16'h0041, 3, 1'b0);
        check_eq("t1_bytes", {8'h0, got_bytes[0], got_bytes[1], got_bytes[2]}, 32'h00223344);
        do_read(16'h0043, 2, 1'b0);
        check_eq("t2_bytes", {16'h0, got_bytes[0], got_bytes[1]}, 32'h00004455);
        do_read(16'h0040, 8, 1'b1);
        check_eq("t4_b7", 32'(got_bytes[7]), 32'h88);
        do_read(16'h0040, 8, 1'b0);
        do_read(16'hFFFF, 2, 1'b0);
        do_read(16'h1235, 0, 1'b0);
        do_write(16'h0046, 8'hAB);
        do_read(16'h0046, 1, 1'b0);
        check_eq("t3_readback", 32'(got_bytes[0]), 32'hAB);

        // Reset while bytes are being presented
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0040;
        cmd_len   = 8'd8;
        rd_ready  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!rd_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("rst6_reach_out", 32'(rd_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        check_eq("rst6_rd_valid", 32'(rd_valid), 32'h0);
        check_eq("rst6_rd_last", 32'(rd_last), 32'h0);
        check_eq("rst6_cs", 32'(avm_chipselect), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst6_no_done", 32'(done), 32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst6_no_done_after", 32'(done), 32'h0);
        do_read(16'h0041, 3, 1'b0);

        // Randomized mix of reads and writes
        for (int it = 0; it < 60; it++) begin
            a = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) a = 16'hFFF0 | 16'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) do_write(a, 8'($urandom_range(0, 255)));
            else do_read(a, int'($urandom_range(0, 20)), $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
